// File: rtl/writeback_regfile_pkg.sv
// Shared encodings and sizes for the writeback stage and integer register file.
package writeback_regfile_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int INSTRET_W = 64;
  localparam int REG_W     = 5;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RES_ALU    = 2'b00,
    RES_LOAD   = 2'b01,
    RES_PC4    = 2'b10,
    RES_LAUIPC = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

endpackage

// File: rtl/writeback_regfile_if.sv
// W-stage latch contents, decode read ports and writeback observation signals.
interface writeback_regfile_if
  import writeback_regfile_pkg::*;
();

  logic                 ValidW;
  logic                 RegWriteW;
  logic [1:0]           ResultSrcW;
  logic [2:0]           Funct3W;
  logic [XLEN-1:0]      ALUResultW;
  logic [XLEN-1:0]      ReadDataW;
  logic [XLEN-1:0]      PCPlus4W;
  logic [XLEN-1:0]      lauipcW;
  logic [REG_W-1:0]     RdW;
  logic [REG_W-1:0]     Rs1D;
  logic [REG_W-1:0]     Rs2D;
  logic [XLEN-1:0]      RD1D;
  logic [XLEN-1:0]      RD2D;
  logic [XLEN-1:0]      ResultW;
  logic [INSTRET_W-1:0] InstretW;

  modport master (
    output ValidW, RegWriteW, ResultSrcW, Funct3W, ALUResultW, ReadDataW,
           PCPlus4W, lauipcW, RdW, Rs1D, Rs2D,
    input  RD1D, RD2D, ResultW, InstretW
  );

  modport slave (
    input  ValidW, RegWriteW, ResultSrcW, Funct3W, ALUResultW, ReadDataW,
           PCPlus4W, lauipcW, RdW, Rs1D, Rs2D,
    output RD1D, RD2D, ResultW, InstretW
  );

endinterface

// File: rtl/writeback_regfile_load_formatter.sv
// Extracts and extends the addressed byte/halfword of a loaded word.
module writeback_regfile_load_formatter
  import writeback_regfile_pkg::*;
(
  input  logic [XLEN-1:0] read_data,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = read_data[7:0];
    case (offset)
      2'd1:    sel_byte = read_data[15:8];
      2'd2:    sel_byte = read_data[23:16];
      2'd3:    sel_byte = read_data[31:24];
      default: sel_byte = read_data[7:0];
    endcase
  end

  // Halfword select uses offset[1] only; an odd address is not trapped here.
  assign sel_half = offset[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    load_word = read_data;
    case (funct3)
      F3_LB:   load_word = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LH:   load_word = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_LBU:  load_word = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LHU:  load_word = {{(XLEN-16){1'b0}}, sel_half};
      default: load_word = read_data;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback result select, integer register file with same-cycle bypass,
// and retired-instruction counter.
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  writeback_regfile_if.slave bus
);

  logic [XLEN-1:0]      regs [NREGS];
  logic [XLEN-1:0]      load_word;
  logic [XLEN-1:0]      result;
  logic                 wr_en;
  logic [INSTRET_W-1:0] instret;

  writeback_regfile_load_formatter u_load_formatter (
    .read_data (bus.ReadDataW),
    .offset    (bus.ALUResultW[1:0]),
    .funct3    (bus.Funct3W),
    .load_word (load_word)
  );

  always_comb begin
    result = bus.ALUResultW;
    case (bus.ResultSrcW)
      RES_LOAD:   result = load_word;
      RES_PC4:    result = bus.PCPlus4W;
      RES_LAUIPC: result = bus.lauipcW;
      default:    result = bus.ALUResultW;
    endcase
  end

  // Bubbles carry stale RegWriteW, so ValidW gates both the write and the bypass.
  assign wr_en = bus.ValidW && bus.RegWriteW && (bus.RdW != REG_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.RdW] <= result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instret <= '0;
    else if (bus.ValidW) instret <= instret + 1'b1;
  end

  always_comb begin
    bus.RD1D = regs[bus.Rs1D];
    if (bus.Rs1D == REG_ZERO)                bus.RD1D = '0;
    else if (wr_en && (bus.Rs1D == bus.RdW)) bus.RD1D = result;
  end

  always_comb begin
    bus.RD2D = regs[bus.Rs2D];
    if (bus.Rs2D == REG_ZERO)                bus.RD2D = '0;
    else if (wr_en && (bus.Rs2D == bus.RdW)) bus.RD2D = result;
  end

  assign bus.ResultW  = result;
  assign bus.InstretW = instret;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, bypass, load formatting, x0, bubbles, link/lui.
module tb_writeback_regfile;
  import writeback_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [INSTRET_W-1:0] exp_instret = '0;

  logic [2:0]  ld_f3  [8];
  logic [1:0]  ld_off [8];
  logic [31:0] ld_exp [8];

  writeback_regfile_if wb ();

  writeback_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wb)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wb.ValidW     = 1'b0;
    wb.RegWriteW  = 1'b0;
    wb.ResultSrcW = RES_ALU;
    wb.Funct3W    = 3'b000;
    wb.ALUResultW = '0;
    wb.ReadDataW  = '0;
    wb.PCPlus4W   = '0;
    wb.lauipcW    = '0;
    wb.RdW        = '0;
    wb.Rs1D       = '0;
    wb.Rs2D       = '0;
  endtask

  task automatic tick();
    if (wb.ValidW) exp_instret = exp_instret + 1'b1;
    @(posedge clk);
  endtask

  task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
    @(negedge clk);
    idle();
    wb.ValidW = 1'b1; wb.RegWriteW = 1'b1; wb.RdW = rd; wb.ALUResultW = val;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    wb.Rs1D = 5'd5;
    #12;
    n_checks++;
    if (wb.InstretW !== 64'd0) begin
      n_fail++; $display("FAIL reset_instret: got %0h expected 0", wb.InstretW);
    end
    n_checks++;
    if (wb.RD1D !== 32'd0) begin
      n_fail++; $display("FAIL reset_x5: got %h expected 0", wb.RD1D);
    end
    @(negedge clk);
    rst_n = 1'b1;
    alu_write(5'd5, 32'h0000_00AA);
    @(negedge clk);
    idle();
    wb.Rs1D = 5'd5;
    #1;
    n_checks++;
    if (wb.RD1D !== 32'h0000_00AA) begin
      n_fail++; $display("FAIL reset_prewrite_x5: got %h expected 000000aa", wb.RD1D);
    end
    n_checks++;
    if (wb.InstretW !== 64'd1) begin
      n_fail++; $display("FAIL reset_prewrite_instret: got %0h expected 1", wb.InstretW);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_instret = '0;
    n_checks++;
    if (wb.RD1D !== 32'd0) begin
      n_fail++; $display("FAIL reset_async_x5: got %h expected 0", wb.RD1D);
    end
    n_checks++;
    if (wb.InstretW !== 64'd0) begin
      n_fail++; $display("FAIL reset_async_instret: got %0h expected 0", wb.InstretW);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_bypass();
    @(negedge clk);
    idle();
    wb.ValidW = 1'b1; wb.RegWriteW = 1'b1; wb.RdW = 5'd7;
    wb.ALUResultW = 32'h0000_1234; wb.Rs1D = 5'd7;
    #1;
    n_checks++;
    if (wb.RD1D !== 32'h0000_1234) begin
      n_fail++; $display("FAIL alu_bypass: got %h expected 00001234", wb.RD1D);
    end
    tick();
    @(negedge clk);
    idle();
    wb.Rs1D = 5'd7;
    #1;
    n_checks++;
    if (wb.RD1D !== 32'h0000_1234) begin
      n_fail++; $display("FAIL alu_stored: got %h expected 00001234", wb.RD1D);
    end
  endtask

  task automatic test_loads();
    ld_f3  = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011};
    ld_off = '{2'd1,   2'd3,   2'd2,   2'd2,   2'd0,   2'd0,   2'd3,   2'd1};
    ld_exp = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
               32'h0000_7F01, 32'h80FF_7F01, 32'hFFFF_80FF, 32'h80FF_7F01};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      wb.ValidW = 1'b1; wb.RegWriteW = 1'b1; wb.RdW = 5'd10;
      wb.ResultSrcW = RES_LOAD; wb.ReadDataW = 32'h80FF_7F01;
      wb.Funct3W = ld_f3[i];
      wb.ALUResultW = {30'h0000_0100, ld_off[i]};
      wb.Rs1D = 5'd10;
      #1;
      n_checks++;
      if (wb.ResultW !== ld_exp[i]) begin
        n_fail++;
        $display("FAIL load_fmt[%0d] f3=%b off=%0d: got %h expected %h",
                 i, ld_f3[i], ld_off[i], wb.ResultW, ld_exp[i]);
      end
      tick();
    end
    @(negedge clk);
    idle();
    wb.Rs2D = 5'd10;
    #1;
    n_checks++;
    if (wb.RD2D !== 32'h80FF_7F01) begin
      n_fail++; $display("FAIL load_stored_x10: got %h expected 80ff7f01", wb.RD2D);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle();
    wb.ValidW = 1'b1; wb.RegWriteW = 1'b1; wb.RdW = 5'd0;
    wb.ALUResultW = 32'hDEAD_BEEF; wb.Rs1D = 5'd0; wb.Rs2D = 5'd0;
    #1;
    n_checks++;
    if (wb.RD1D !== 32'd0) begin
      n_fail++; $display("FAIL x0_no_bypass: got %h expected 0", wb.RD1D);
    end
    n_checks++;
    if (wb.ResultW !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL x0_result: got %h expected deadbeef", wb.ResultW);
    end
    tick();
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (wb.RD2D !== 32'd0) begin
      n_fail++; $display("FAIL x0_after_write: got %h expected 0", wb.RD2D);
    end
  endtask

  task automatic test_bubble();
    alu_write(5'd3, 32'h0000_0033);
    @(negedge clk);
    idle();
    wb.ValidW = 1'b0; wb.RegWriteW = 1'b1; wb.RdW = 5'd3;
    wb.ALUResultW = 32'h0000_0099; wb.Rs1D = 5'd3;
    #1;
    n_checks++;
    if (wb.RD1D !== 32'h0000_0033) begin
      n_fail++; $display("FAIL bubble_no_bypass: got %h expected 00000033", wb.RD1D);
    end
    tick();
    @(negedge clk);
    idle();
    wb.Rs1D = 5'd3;
    #1;
    n_checks++;
    if (wb.RD1D !== 32'h0000_0033) begin
      n_fail++; $display("FAIL bubble_x3_kept: got %h expected 00000033", wb.RD1D);
    end
    n_checks++;
    if (wb.InstretW !== exp_instret) begin
      n_fail++; $display("FAIL bubble_instret_held: got %0d expected %0d", wb.InstretW, exp_instret);
    end
    wb.ValidW = 1'b1; wb.RegWriteW = 1'b0; wb.RdW = 5'd3; wb.ALUResultW = 32'h0000_0077;
    tick();
    @(negedge clk);
    idle();
    wb.Rs1D = 5'd3;
    #1;
    n_checks++;
    if (wb.InstretW !== exp_instret) begin
      n_fail++; $display("FAIL store_instret_inc: got %0d expected %0d", wb.InstretW, exp_instret);
    end
    n_checks++;
    if (wb.RD1D !== 32'h0000_0033) begin
      n_fail++; $display("FAIL store_no_write: got %h expected 00000033", wb.RD1D);
    end
  endtask

  task automatic test_link_lui();
    @(negedge clk);
    idle();
    wb.ValidW = 1'b1; wb.RegWriteW = 1'b1; wb.RdW = 5'd1;
    wb.ResultSrcW = RES_PC4; wb.PCPlus4W = 32'h0000_0104; wb.ALUResultW = 32'h0000_0555;
    tick();
    @(negedge clk);
    idle();
    wb.ValidW = 1'b1; wb.RegWriteW = 1'b1; wb.RdW = 5'd9;
    wb.ResultSrcW = RES_LAUIPC; wb.lauipcW = 32'h1234_5000; wb.ALUResultW = 32'h0000_0666;
    wb.Rs1D = 5'd9; wb.Rs2D = 5'd9;
    #1;
    n_checks++;
    if (wb.ResultW !== 32'h1234_5000) begin
      n_fail++; $display("FAIL lui_result: got %h expected 12345000", wb.ResultW);
    end
    n_checks++;
    if (wb.RD1D !== 32'h1234_5000) begin
      n_fail++; $display("FAIL lui_bypass_rd1: got %h expected 12345000", wb.RD1D);
    end
    n_checks++;
    if (wb.RD2D !== 32'h1234_5000) begin
      n_fail++; $display("FAIL lui_bypass_rd2: got %h expected 12345000", wb.RD2D);
    end
    tick();
    @(negedge clk);
    idle();
    wb.Rs1D = 5'd1; wb.Rs2D = 5'd9;
    #1;
    n_checks++;
    if (wb.RD1D !== 32'h0000_0104) begin
      n_fail++; $display("FAIL link_x1: got %h expected 00000104", wb.RD1D);
    end
    n_checks++;
    if (wb.RD2D !== 32'h1234_5000) begin
      n_fail++; $display("FAIL lui_x9: got %h expected 12345000", wb.RD2D);
    end
  endtask

  task automatic test_back_to_back();
    alu_write(5'd20, 32'hA5A5_0001);
    @(negedge clk);
    idle();
    wb.ValidW = 1'b1; wb.RegWriteW = 1'b1; wb.RdW = 5'd21;
    wb.ALUResultW = 32'h5A5A_0002; wb.Rs1D = 5'd20; wb.Rs2D = 5'd21;
    #1;
    n_checks++;
    if (wb.RD1D !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL b2b_prev_write: got %h expected a5a50001", wb.RD1D);
    end
    n_checks++;
    if (wb.RD2D !== 32'h5A5A_0002) begin
      n_fail++; $display("FAIL b2b_bypass: got %h expected 5a5a0002", wb.RD2D);
    end
    tick();
    @(negedge clk);
    idle();
    wb.Rs1D = 5'd21; wb.Rs2D = 5'd20;
    #1;
    n_checks++;
    if (wb.RD1D !== 32'h5A5A_0002) begin
      n_fail++; $display("FAIL b2b_x21: got %h expected 5a5a0002", wb.RD1D);
    end
    n_checks++;
    if (wb.InstretW !== exp_instret) begin
      n_fail++; $display("FAIL b2b_instret: got %0d expected %0d", wb.InstretW, exp_instret);
    end
  endtask

  task automatic test_reset_discard();
    @(negedge clk);
    idle();
    wb.ValidW = 1'b1; wb.RegWriteW = 1'b1; wb.RdW = 5'd12; wb.ALUResultW = 32'h0000_0055;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = '0;
    idle();
    wb.Rs1D = 5'd12; wb.Rs2D = 5'd21;
    #1;
    n_checks++;
    if (wb.RD1D !== 32'd0) begin
      n_fail++; $display("FAIL reset_discard_x12: got %h expected 0", wb.RD1D);
    end
    n_checks++;
    if (wb.RD2D !== 32'd0) begin
      n_fail++; $display("FAIL reset_clear_x21: got %h expected 0", wb.RD2D);
    end
    n_checks++;
    if (wb.InstretW !== 64'd0) begin
      n_fail++; $display("FAIL reset_discard_instret: got %0d expected 0", wb.InstretW);
    end
  endtask

  initial begin
    test_reset();
    test_alu_bypass();
    test_loads();
    test_x0();
    test_bubble();
    test_link_lui();
    test_back_to_back();
    test_reset_discard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
